// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4:1 mux select scanner that samples one bit per channel into a frame (optional macro: SCAN_SKIP_EN)
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       y,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic       done,
   output logic [3:0] frame
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t     state_q;
   logic [3:0] mask_q;
   logic [1:0] ch_q;
   logic [3:0] cnt_q;
   logic [1:0] sel_q;
   logic       busy_q;
   logic       done_q;
   logic [3:0] frame_q;

   logic [3:0] launch_mask_d;
   logic [2:0] first_hit_d;
   logic [2:0] next_hit_d;
   logic       dwell_end_d;

   // Lowest enabled channel at or above 'from'; bit 2 set means none left.
   function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b100;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= from)) begin
            r = {1'b0, 2'(i)};
         end
      end
      return r;
   endfunction

   // Channel selection helpers: which channels a new scan visits and where the current one goes next.
   always_comb begin
`ifdef SCAN_SKIP_EN
      launch_mask_d = mask;
`else
      // mask has no effect here: every channel is forced on.
      launch_mask_d = mask | 4'hF;
`endif
      first_hit_d = find_from(launch_mask_d, 3'd0);
      next_hit_d  = find_from(mask_q, {1'b0, ch_q} + 3'd1);
      dwell_end_d = (cnt_q == DWELL_LAST);
   end

   // Scan FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= 4'b0000;
         ch_q    <= 2'd0;
         cnt_q   <= 4'd0;
         sel_q   <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         frame_q <= 4'b0000;
      end else begin
         case (state_q)
            ST_SCAN: begin
               if (dwell_end_d) begin
                  frame_q[ch_q] <= y;
                  cnt_q         <= 4'd0;
                  if (next_hit_d[2]) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     sel_q   <= 2'b00;
                  end else begin
                     ch_q  <= next_hit_d[1:0];
                     sel_q <= next_hit_d[1:0];
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               // IDLE, and the edge leaving DONE, which is the first edge back in IDLE
               // so a held start chains scans back to back.
               done_q <= 1'b0;
               busy_q <= 1'b0;
               sel_q  <= 2'b00;
               if (start) begin
                  mask_q  <= launch_mask_d;
                  frame_q <= 4'b0000;
                  cnt_q   <= 4'd0;
                  if (first_hit_d[2]) begin
                     state_q <= ST_DONE;
                     ch_q    <= 2'd0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SCAN;
                     ch_q    <= first_hit_d[1:0];
                     sel_q   <= first_hit_d[1:0];
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign s0    = sel_q[0];
   assign s1    = sel_q[1];
   assign busy  = busy_q;
   assign done  = done_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

   localparam int DW = 2;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] mask;
   logic [3:0] d;
   logic       y;
   logic       s0, s1, busy, done;
   logic [3:0] frame;

   logic       y2;
   logic       s0b, s1b, busy2, done2;
   logic [3:0] frame2;
   logic [3:0] d2;

   int n_checks;
   int n_errors;
   int cyc;
   int prev2;
   logic [3:0] hold_frame;

   typedef struct {
      int         done_edge;
      logic [3:0] frame;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] sel_q[$];

   assign y  = d[{s1, s0}];
   assign y2 = d2[{s1b, s0b}];

   mux_scan_ctrl #(.DWELL(DW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mask  (mask),
      .y     (y),
      .s0    (s0),
      .s1    (s1),
      .busy  (busy),
      .done  (done),
      .frame (frame)
   );

   mux_scan_ctrl #(.DWELL(1)) u_dut_b2b (
      .clk   (clk),
      .rst_n (rst_n),
      .start (1'b1),
      .mask  (4'hF),
      .y     (y2),
      .s0    (s0b),
      .s1    (s1b),
      .busy  (busy2),
      .done  (done2),
      .frame (frame2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: the scan visits enabled channels in ascending order, DWELL cycles each.
   function automatic void push_scan(input logic [3:0] m, input logic [3:0] dd, input int accept);
      logic [3:0] em;
      int         n;
      exp_t       e;
`ifdef SCAN_SKIP_EN
      em = m;
`else
      em = 4'hF;
`endif
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (em[i]) begin
            n++;
            for (int k = 0; k < DW; k++) sel_q.push_back(2'(i));
         end
      end
      e.done_edge = accept + n * DW;
      e.frame     = dd & em;
      exp_q.push_back(e);
   endfunction

   // Monitor for the main DUT: select sequence, busy span, done timing, frame content and hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) begin
            if (sel_q.size() == 0) chk("busy_extra", {31'd0, busy}, 32'd0);
            else chk("sel", {30'd0, s1, s0}, {30'd0, sel_q.pop_front()});
         end else begin
            chk("sel_idle", {30'd0, s1, s0}, 32'd0);
         end
         if (done) begin
            chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_edge", cyc, e.done_edge);
               chk("frame", {28'd0, frame}, {28'd0, e.frame});
               chk("busy_span", sel_q.size(), 32'd0);
               hold_frame = e.frame;
            end
         end else begin
            if (!busy) chk("frame_hold", {28'd0, frame}, {28'd0, hold_frame});
            if (exp_q.size() != 0 && cyc > exp_q[0].done_edge) begin
               chk("done_late", cyc, exp_q[0].done_edge);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Monitor for the back-to-back DUT: start held high, period 4*1+1 cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev2 = -1;
      end else if (done2) begin
         chk("b2b_frame", {28'd0, frame2}, 32'h6);
         if (prev2 >= 0) chk("b2b_period", cyc - prev2, 32'd5);
         prev2 = cyc;
      end
   end

   task automatic launch(input logic [3:0] m, input logic [3:0] dd);
      d     = dd;
      mask  = m;
      start = 1'b1;
      push_scan(m, dd, cyc + 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
         @(negedge clk);
         mask = 4'($urandom);
      end
      @(negedge clk);
      if (exp_q.size() != 0) begin
         chk("drain", exp_q.size(), 32'd0);
         exp_q.delete();
         sel_q.delete();
      end
   endtask

   task automatic do_scan(input logic [3:0] m, input logic [3:0] dd);
      @(negedge clk);
      launch(m, dd);
      @(negedge clk);
      start = 1'b0;
      drain();
   endtask

   initial begin
      clk        = 1'b0;
      rst_n      = 1'b0;
      start      = 1'b0;
      mask       = 4'h0;
      d          = 4'h0;
      d2         = 4'b0110;
      cyc        = 0;
      prev2      = -1;
      n_checks   = 0;
      n_errors   = 0;
      hold_frame = 4'h0;

      #23;
      chk("rst_s0", {31'd0, s0}, 32'd0);
      chk("rst_s1", {31'd0, s1}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_frame", {28'd0, frame}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_scan(4'hF, 4'b1010);
      do_scan(4'b1001, 4'b1111);
      do_scan(4'b0000, 4'b1111);
      do_scan(4'hF, 4'b0101);
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // Abort in the third SCAN cycle; outputs must clear without waiting for a clock.
      @(negedge clk);
      launch(4'hF, 4'b1111);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      hold_frame = 4'h0;
      exp_q.delete();
      sel_q.delete();
      rst_n = 1'b0;
      #1;
      chk("abort_s0", {31'd0, s0}, 32'd0);
      chk("abort_s1", {31'd0, s1}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_frame", {28'd0, frame}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      launch(4'hF, 4'($urandom_range(0, 15)));
      @(negedge clk);
      start = 1'b0;
      drain();

      do_scan(4'hF, 4'b1100);
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, 2, cycles each select code is held before the mux output is sampled (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  scan request; sampled only in IDLE.
REQ-005 Port: mask  input  4  per-channel enable (bit i = channel i); latched when start is accepted.
REQ-006 Port: y  input  1  output of the downstream 4:1 mux.
REQ-007 Port: s0  output  1  select LSB to the mux.
REQ-008 Port: s1  output  1  select MSB to the mux.
REQ-009 Port: busy  output  1  high while a scan is in progress.
REQ-010 Port: done  output  1  one-cycle pulse at scan completion.
REQ-011 Port: frame  output  4  sampled y per channel (bit i = channel i).

Function
REQ-012 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst_n).
REQ-013 The block SHALL implement the states IDLE, SCAN and DONE.
REQ-014 IDLE -> SCAN SHALL occur on a clock edge with start=1, latching mask, clearing frame to 0, setting the channel to the first scanned channel and the dwell counter to 0.
REQ-015 In SCAN, {s1,s0} SHALL equal the current channel number; in IDLE and DONE, {s1,s0} SHALL be 2'b00.
REQ-016 In SCAN, the dwell counter SHALL increment each cycle; on the edge where it equals DWELL-1, y SHALL be written to frame[channel].
REQ-017 On that same edge, the block SHALL go to DONE if the channel is the last scanned channel; otherwise it SHALL advance to the next scanned channel and clear the counter.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 exactly while in SCAN.
REQ-020 All outputs SHALL be registered.
REQ-021 For N scanned channels, done SHALL be high in the cycle starting N*DWELL edges after the start-accepting edge (4*DWELL when all four channels are scanned).
REQ-022 start SHALL be ignored in SCAN and DONE; a start held high through DONE SHALL begin a new scan on the first IDLE edge.
REQ-023 frame SHALL hold its value from done until the next accepted start.
REQ-024 Changes on mask during SCAN SHALL have no effect.
REQ-025 The channel counter SHALL never exceed 3 and SHALL not wrap within a scan.

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE with s0=0, s1=0, busy=0, done=0, frame=4'b0000, counter=0 and channel=0, regardless of clk.
REQ-027 A reset asserted mid-scan SHALL abort the scan immediately without producing a done pulse.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising clk edge.

Configuration
REQ-029 Macro SCAN_SKIP_EN, when defined, SHALL cause only channels with a latched mask bit of 1 to be scanned, in ascending order; frame bits of skipped channels SHALL remain 0.
REQ-030 With SCAN_SKIP_EN defined and mask=4'b0000, the block SHALL enter DONE directly from IDLE (done one cycle after start) with frame=0 and busy never asserted.
REQ-031 With SCAN_SKIP_EN undefined, mask SHALL be ignored and channels 0,1,2,3 SHALL always be scanned.

Verification
REQ-032 DWELL=2, y driven = d[{s1,s0}] with d=4'b1010, start pulse -> select sequence 00,00,01,01,10,10,11,11; done 8 cycles after start; frame=4'b1010; busy high for 8 cycles.
REQ-033 DWELL=1, d=4'b0110, start held high continuously -> back-to-back scans, frame=4'b0110 at each done, done every 5 cycles.
REQ-034 SCAN_SKIP_EN defined, DWELL=2, mask=4'b1001, d=4'b1111 -> select shows only 00 and 11; done 4 cycles after start; frame=4'b1001.
REQ-035 SCAN_SKIP_EN defined, mask=4'b0000 -> done one cycle after start, busy=0, frame=0.
REQ-036 rst_n pulled low during the third SCAN cycle -> outputs zero asynchronously, no done; the next start yields a full correct scan.
REQ-037 mask changed from 4'b1111 to 4'b0001 mid-scan (SCAN_SKIP_EN defined) -> scan completes over the originally latched four channels.
